// File: rtl/ram_pkg.sv
// ram_pkg: shared defaults and state encodings for the RAM port responder
package ram_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 6;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} mode_t;
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} port_st_t;
endpackage

// File: rtl/ram_port_responder_if.sv
// ram_port_responder_if: request/response handshakes for ports A and B
interface ram_port_responder_if #(
  parameter int DATA_W = ram_pkg::DEF_DATA_W,
  parameter int ADDR_W = ram_pkg::DEF_ADDR_W
);
  logic              req_valid_a, req_ready_a, req_we_a;
  logic [ADDR_W-1:0] req_addr_a;
  logic [DATA_W-1:0] req_data_a;
  logic              rsp_valid_a, rsp_ready_a, rsp_err_a;
  logic [DATA_W-1:0] rsp_data_a;
  logic              req_valid_b, req_ready_b, req_we_b;
  logic [ADDR_W-1:0] req_addr_b;
  logic [DATA_W-1:0] req_data_b;
  logic              rsp_valid_b, rsp_ready_b, rsp_err_b;
  logic [DATA_W-1:0] rsp_data_b;
  modport master (
    output req_valid_a, req_we_a, req_addr_a, req_data_a, rsp_ready_a,
    output req_valid_b, req_we_b, req_addr_b, req_data_b, rsp_ready_b,
    input  req_ready_a, rsp_valid_a, rsp_data_a, rsp_err_a,
    input  req_ready_b, rsp_valid_b, rsp_data_b, rsp_err_b
  );
  modport slave (
    input  req_valid_a, req_we_a, req_addr_a, req_data_a, rsp_ready_a,
    input  req_valid_b, req_we_b, req_addr_b, req_data_b, rsp_ready_b,
    output req_ready_a, rsp_valid_a, rsp_data_a, rsp_err_a,
    output req_ready_b, rsp_valid_b, rsp_data_b, rsp_err_b
  );
endinterface

// File: rtl/dpram_core.sv
// dpram_core: two-port single-clock RAM, read-first, port A wins same-address writes
module dpram_core #(
  parameter int DATA_W = ram_pkg::DEF_DATA_W,
  parameter int ADDR_W = ram_pkg::DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // A's write is issued last so it overrides B on the same address
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= wdata_b;
    if (we_a) mem[addr_a] <= wdata_a;
  end
  assign rdata_a = mem[addr_a];
  assign rdata_b = mem[addr_b];
endmodule

// File: rtl/ram_port_responder.sv
// ram_port_responder: clears RAM after reset, then serves two request/response ports
module ram_port_responder
  import ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_port_responder_if.slave   bus,
  output logic                  clearing,
  output logic [7:0]            collision_count
);
  localparam int DEPTH = 2**ADDR_W;
  mode_t mode, mode_nxt;
  port_st_t st_a, st_a_nxt, st_b, st_b_nxt;
  logic [ADDR_W:0] clr_cnt;
  logic acc_a, acc_b, same, ww, bump, we_a, we_b;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a, rdata_a, rdata_b, rsp_data_a, rsp_data_b;
  logic rsp_err_a, rsp_err_b;
  assign clearing = mode == CLEAR;
  assign bus.req_ready_a = !clearing && (st_a == IDLE || bus.rsp_ready_a);
  assign bus.req_ready_b = !clearing && (st_b == IDLE || bus.rsp_ready_b);
  assign bus.rsp_valid_a = st_a == RESP;
  assign bus.rsp_valid_b = st_b == RESP;
  assign bus.rsp_data_a = rsp_data_a;
  assign bus.rsp_data_b = rsp_data_b;
  assign bus.rsp_err_a = rsp_err_a;
  assign bus.rsp_err_b = rsp_err_b;
  assign acc_a = bus.req_valid_a && bus.req_ready_a;
  assign acc_b = bus.req_valid_b && bus.req_ready_b;
  assign same = acc_a && acc_b && bus.req_addr_a == bus.req_addr_b;
  assign ww = same && bus.req_we_a && bus.req_we_b;
  assign bump = same && (bus.req_we_a || bus.req_we_b) && collision_count != 8'hFF;
  // the clear sweep borrows port A; no requests are accepted meanwhile
  assign we_a = clearing || (acc_a && bus.req_we_a);
  assign addr_a = clearing ? clr_cnt[ADDR_W-1:0] : bus.req_addr_a;
  assign wdata_a = clearing ? '0 : bus.req_data_a;
  assign we_b = acc_b && bus.req_we_b && !ww;
  dpram_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .rdata_a(rdata_a),
    .we_b(we_b), .addr_b(bus.req_addr_b), .wdata_b(bus.req_data_b), .rdata_b(rdata_b)
  );
  always_comb begin
    mode_nxt = (clearing && clr_cnt == (ADDR_W+1)'(DEPTH-1)) ? RUN : mode;
    st_a_nxt = acc_a ? RESP : (st_a == RESP && bus.rsp_ready_a) ? IDLE : st_a;
    st_b_nxt = acc_b ? RESP : (st_b == RESP && bus.rsp_ready_b) ? IDLE : st_b;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode <= CLEAR;
      st_a <= IDLE;
      st_b <= IDLE;
      clr_cnt <= '0;
      collision_count <= '0;
      rsp_data_a <= '0;
      rsp_data_b <= '0;
      rsp_err_a <= 1'b0;
      rsp_err_b <= 1'b0;
    end else begin
      mode <= mode_nxt;
      st_a <= st_a_nxt;
      st_b <= st_b_nxt;
      if (clearing) clr_cnt <= clr_cnt + (ADDR_W+1)'(1);
      if (bump) collision_count <= collision_count + 8'd1;
      if (acc_a) begin
        rsp_data_a <= bus.req_we_a ? bus.req_data_a : rdata_a;
        rsp_err_a <= 1'b0;
      end
      // a dropped B write reports the data that A actually stored
      if (acc_b) begin
        rsp_data_b <= ww ? bus.req_data_a : bus.req_we_b ? bus.req_data_b : rdata_b;
        rsp_err_b <= ww;
      end
    end
  end
endmodule
